// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding, port ids
// and default bus widths.
package mem_arb_pkg;

  localparam int AW_DEF = 24;
  localparam int DW_DEF = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and Memory signals of the arbiter grouped as one bundle;
// slave is the arbiter's view, master is the view of whatever drives it.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          wr0;
  logic          wr1;
  logic          len0;
  logic          len1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic          busy;

  logic [AW-1:0] mem_addr;
  logic          mem_length;
  logic          mem_rd;
  logic          mem_wr;
  logic          mem_enable;
  logic [DW-1:0] to_mem_data;
  logic [DW-1:0] from_mem_data;
  logic          mem_rdy;

  modport slave (
    input  req0, req1, addr0, addr1, wr0, wr1, len0, len1, wdata0, wdata1,
    input  from_mem_data, mem_rdy,
    output ack0, ack1, rdata, busy,
    output mem_addr, mem_length, mem_rd, mem_wr, mem_enable, to_mem_data
  );

  modport master (
    output req0, req1, addr0, addr1, wr0, wr1, len0, len1, wdata0, wdata1,
    output from_mem_data, mem_rdy,
    input  ack0, ack1, rdata, busy,
    input  mem_addr, mem_length, mem_rd, mem_wr, mem_enable, to_mem_data
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select between fetch and data ports.
// ARB_ROUND_ROBIN_EN selects alternating ties; otherwise the data port always wins.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic i_last_grant,
`endif
  output logic o_grant,
  output logic o_valid
);

  always_comb begin
    o_valid = i_req0 | i_req1;
    o_grant = PORT_FETCH;
    case ({i_req1, i_req0})
      2'b01:   o_grant = PORT_FETCH;
      2'b10:   o_grant = PORT_DATA;
`ifdef ARB_ROUND_ROBIN_EN
      // The port that was not served last takes the tie.
      2'b11:   o_grant = ~i_last_grant;
`else
      2'b11:   o_grant = PORT_DATA;
`endif
      default: o_grant = PORT_FETCH;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single Memory port: IDLE -> ACCESS -> RESP.
// Optional ARB_ROUND_ROBIN_EN turns fixed priority into alternating tie-break.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
)(
  input logic               i_clk,
  input logic               i_reset,
  mem_port_arbiter_if.slave bus
);

  state_t        r_state;
  state_t        w_state_nxt;

  logic          w_grant;
  logic          w_valid;
  logic          r_grant;

  logic [AW-1:0] w_sel_addr;
  logic          w_sel_wr;
  logic          w_sel_len;
  logic [DW-1:0] w_sel_wdata;

  logic          w_load;
  logic          w_capture;
  logic          w_enable_nxt;
  logic          w_rd_nxt;
  logic          w_wr_nxt;
  logic          w_ack0_nxt;
  logic          w_ack1_nxt;
  logic          w_busy_nxt;

  logic [AW-1:0] r_mem_addr;
  logic          r_mem_length;
  logic          r_mem_rd;
  logic          r_mem_wr;
  logic          r_mem_enable;
  logic [DW-1:0] r_to_mem_data;
  logic [DW-1:0] r_rdata;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_busy;

`ifdef ARB_ROUND_ROBIN_EN
  logic          r_last_grant;

  arb_pick u_pick (
    .i_req0       (bus.req0),
    .i_req1       (bus.req1),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_valid      (w_valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_grant <= PORT_FETCH;
    end else if (w_load) begin
      r_last_grant <= w_grant;
    end
  end
`else
  arb_pick u_pick (
    .i_req0  (bus.req0),
    .i_req1  (bus.req1),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );
`endif

  always_comb begin
    if (w_grant == PORT_DATA) begin
      w_sel_addr  = bus.addr1;
      w_sel_wr    = bus.wr1;
      w_sel_len   = bus.len1;
      w_sel_wdata = bus.wdata1;
    end else begin
      w_sel_addr  = bus.addr0;
      w_sel_wr    = bus.wr0;
      w_sel_len   = bus.len0;
      w_sel_wdata = bus.wdata0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (bus.mem_rdy) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, so every output comes straight from a flop.
  always_comb begin
    w_load       = 1'b0;
    w_capture    = 1'b0;
    w_enable_nxt = 1'b0;
    w_rd_nxt     = 1'b0;
    w_wr_nxt     = 1'b0;
    w_ack0_nxt   = 1'b0;
    w_ack1_nxt   = 1'b0;
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          w_load       = 1'b1;
          w_enable_nxt = 1'b1;
          w_rd_nxt     = ~w_sel_wr;
          w_wr_nxt     = w_sel_wr;
        end else begin
          w_load       = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (bus.mem_rdy) begin
          w_capture  = r_mem_rd;
          w_ack0_nxt = (r_grant == PORT_FETCH);
          w_ack1_nxt = (r_grant == PORT_DATA);
        end else begin
          w_enable_nxt = 1'b1;
          w_rd_nxt     = r_mem_rd;
          w_wr_nxt     = r_mem_wr;
        end
      end
      ST_RESP: w_load = 1'b0;
      default: w_load = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_grant       <= PORT_FETCH;
      r_mem_addr    <= {AW{1'b0}};
      r_mem_length  <= 1'b0;
      r_to_mem_data <= {DW{1'b0}};
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_enable  <= 1'b0;
      r_rdata       <= {DW{1'b0}};
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_mem_enable <= w_enable_nxt;
      r_mem_rd     <= w_rd_nxt;
      r_mem_wr     <= w_wr_nxt;
      r_ack0       <= w_ack0_nxt;
      r_ack1       <= w_ack1_nxt;
      r_busy       <= w_busy_nxt;
      if (w_load) begin
        r_grant       <= w_grant;
        r_mem_addr    <= w_sel_addr;
        r_mem_length  <= w_sel_len;
        r_to_mem_data <= w_sel_wdata;
      end
      // Writes complete without touching the last read data.
      if (w_capture) begin
        r_rdata <= bus.from_mem_data;
      end
    end
  end

  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_length  = r_mem_length;
  assign bus.mem_rd      = r_mem_rd;
  assign bus.mem_wr      = r_mem_wr;
  assign bus.mem_enable  = r_mem_enable;
  assign bus.to_mem_data = r_to_mem_data;
  assign bus.rdata       = r_rdata;
  assign bus.ack0        = r_ack0;
  assign bus.ack1        = r_ack1;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; ctl = {MemEnable, MemRd, MemWr, Busy, Ack0, Ack1}.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  wire [5:0] ctl = {bus.mem_enable, bus.mem_rd, bus.mem_wr, bus.busy, bus.ack0, bus.ack1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = 24'h0; bus.addr1 = 24'h0;
    bus.wr0 = 1'b0; bus.wr1 = 1'b0;
    bus.len0 = 1'b0; bus.len1 = 1'b0;
    bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
    bus.from_mem_data = 32'h0; bus.mem_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    n_vec++; if (ctl !== 6'b000000) begin n_err++; $display("FAIL rst_ctl: got %b want %b", ctl, 6'b000000); end
    n_vec++; if (bus.mem_addr !== 24'h0) begin n_err++; $display("FAIL rst_addr: got %h want %h", bus.mem_addr, 24'h0); end
    n_vec++; if (bus.to_mem_data !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h want %h", bus.to_mem_data, 32'h0); end
    n_vec++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want %h", bus.rdata, 32'h0); end
    n_vec++; if (bus.mem_length !== 1'b0) begin n_err++; $display("FAIL rst_len: got %b want %b", bus.mem_length, 1'b0); end
    rst = 1'b0;
    tick();
    n_vec++; if (ctl !== 6'b000000) begin n_err++; $display("FAIL rst_idle_ctl: got %b want %b", ctl, 6'b000000); end
  endtask

  task automatic test_read();
    bus.req0 = 1'b1; bus.addr0 = 24'h000100; bus.wr0 = 1'b0; bus.len0 = 1'b1;
    tick();
    n_vec++; if (ctl !== 6'b110100) begin n_err++; $display("FAIL rd_access_ctl: got %b want %b", ctl, 6'b110100); end
    n_vec++; if (bus.mem_addr !== 24'h000100) begin n_err++; $display("FAIL rd_addr: got %h want %h", bus.mem_addr, 24'h000100); end
    n_vec++; if (bus.mem_length !== 1'b1) begin n_err++; $display("FAIL rd_len: got %b want %b", bus.mem_length, 1'b1); end
    bus.mem_rdy = 1'b1; bus.from_mem_data = 32'hDEADBEEF;
    tick();
    n_vec++; if (ctl !== 6'b000110) begin n_err++; $display("FAIL rd_resp_ctl: got %b want %b", ctl, 6'b000110); end
    n_vec++; if (bus.rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata: got %h want %h", bus.rdata, 32'hDEADBEEF); end
    bus.req0 = 1'b0; bus.mem_rdy = 1'b0; bus.from_mem_data = 32'h0;
    tick();
    n_vec++; if (ctl !== 6'b000000) begin n_err++; $display("FAIL rd_idle_ctl: got %b want %b", ctl, 6'b000000); end
    n_vec++; if (bus.rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata_hold: got %h want %h", bus.rdata, 32'hDEADBEEF); end
  endtask

  task automatic test_write_wait();
    bus.req1 = 1'b1; bus.wr1 = 1'b1; bus.addr1 = 24'h00FFFC; bus.wdata1 = 32'h12345678; bus.len1 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_vec++; if (ctl !== 6'b101100) begin n_err++; $display("FAIL wr_access_ctl cyc%0d: got %b want %b", c, ctl, 6'b101100); end
      n_vec++; if (bus.mem_addr !== 24'h00FFFC) begin n_err++; $display("FAIL wr_addr cyc%0d: got %h want %h", c, bus.mem_addr, 24'h00FFFC); end
      n_vec++; if (bus.to_mem_data !== 32'h12345678) begin n_err++; $display("FAIL wr_data cyc%0d: got %h want %h", c, bus.to_mem_data, 32'h12345678); end
      if (c == 5) begin
        bus.mem_rdy = 1'b1; bus.from_mem_data = 32'hCAFEF00D;
      end
    end
    tick();
    n_vec++; if (ctl !== 6'b000101) begin n_err++; $display("FAIL wr_resp_ctl: got %b want %b", ctl, 6'b000101); end
    n_vec++; if (bus.rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rdata_kept: got %h want %h", bus.rdata, 32'hDEADBEEF); end
    bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.mem_rdy = 1'b0; bus.from_mem_data = 32'h0;
    tick();
    n_vec++; if (ctl !== 6'b000000) begin n_err++; $display("FAIL wr_single_ack: got %b want %b", ctl, 6'b000000); end
  endtask

  task automatic test_reset_mid_access();
    bus.req0 = 1'b1; bus.addr0 = 24'h000200; bus.wr0 = 1'b0;
    tick();
    n_vec++; if (ctl !== 6'b110100) begin n_err++; $display("FAIL mrst_access_ctl: got %b want %b", ctl, 6'b110100); end
    rst = 1'b1; bus.req0 = 1'b0;
    tick();
    n_vec++; if (ctl !== 6'b000000) begin n_err++; $display("FAIL mrst_ctl1: got %b want %b", ctl, 6'b000000); end
    n_vec++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL mrst_rdata: got %h want %h", bus.rdata, 32'h0); end
    bus.mem_rdy = 1'b1; bus.from_mem_data = 32'h77777777;
    tick();
    n_vec++; if (ctl !== 6'b000000) begin n_err++; $display("FAIL mrst_ctl2: got %b want %b", ctl, 6'b000000); end
    rst = 1'b0;
    tick();
    n_vec++; if (ctl !== 6'b000000) begin n_err++; $display("FAIL mrst_no_ack: got %b want %b", ctl, 6'b000000); end
    bus.mem_rdy = 1'b0; bus.from_mem_data = 32'h0;
  endtask

  task automatic test_tie();
    bus.req0 = 1'b1; bus.addr0 = 24'h000300; bus.wr0 = 1'b0;
    bus.req1 = 1'b1; bus.addr1 = 24'h000400; bus.wr1 = 1'b0;
    tick();
    n_vec++; if (bus.mem_addr !== 24'h000400) begin n_err++; $display("FAIL tie_first_addr: got %h want %h", bus.mem_addr, 24'h000400); end
    bus.mem_rdy = 1'b1; bus.from_mem_data = 32'hA1A1A1A1;
    tick();
    n_vec++; if (ctl !== 6'b000101) begin n_err++; $display("FAIL tie_ack1: got %b want %b", ctl, 6'b000101); end
    n_vec++; if (bus.rdata !== 32'hA1A1A1A1) begin n_err++; $display("FAIL tie_rdata1: got %h want %h", bus.rdata, 32'hA1A1A1A1); end
    bus.req1 = 1'b0; bus.mem_rdy = 1'b0;
    tick();
    n_vec++; if (ctl !== 6'b000000) begin n_err++; $display("FAIL tie_gap: got %b want %b", ctl, 6'b000000); end
    tick();
    n_vec++; if (ctl !== 6'b110100) begin n_err++; $display("FAIL tie_second_ctl: got %b want %b", ctl, 6'b110100); end
    n_vec++; if (bus.mem_addr !== 24'h000300) begin n_err++; $display("FAIL tie_second_addr: got %h want %h", bus.mem_addr, 24'h000300); end
    bus.mem_rdy = 1'b1; bus.from_mem_data = 32'hB0B0B0B0;
    tick();
    n_vec++; if (ctl !== 6'b000110) begin n_err++; $display("FAIL tie_ack0: got %b want %b", ctl, 6'b000110); end
    n_vec++; if (bus.rdata !== 32'hB0B0B0B0) begin n_err++; $display("FAIL tie_rdata0: got %h want %h", bus.rdata, 32'hB0B0B0B0); end
    bus.req0 = 1'b0; bus.mem_rdy = 1'b0;
    tick();
  endtask

  task automatic test_hold_and_resp();
    bus.req0 = 1'b1; bus.addr0 = 24'h000500; bus.wr0 = 1'b0;
    tick();
    bus.mem_rdy = 1'b1; bus.from_mem_data = 32'hC0000001;
    tick();
    n_vec++; if (ctl !== 6'b000110) begin n_err++; $display("FAIL hold_ack0_a: got %b want %b", ctl, 6'b000110); end
    bus.mem_rdy = 1'b0;
    tick();
    n_vec++; if (ctl !== 6'b000000) begin n_err++; $display("FAIL hold_idle: got %b want %b", ctl, 6'b000000); end
    tick();
    n_vec++; if (ctl !== 6'b110100) begin n_err++; $display("FAIL hold_reserve_ctl: got %b want %b", ctl, 6'b110100); end
    n_vec++; if (bus.mem_addr !== 24'h000500) begin n_err++; $display("FAIL hold_reserve_addr: got %h want %h", bus.mem_addr, 24'h000500); end
    bus.mem_rdy = 1'b1; bus.from_mem_data = 32'hC0000002;
    tick();
    n_vec++; if (bus.rdata !== 32'hC0000002) begin n_err++; $display("FAIL hold_rdata_b: got %h want %h", bus.rdata, 32'hC0000002); end
    bus.req0 = 1'b0; bus.mem_rdy = 1'b0;
    bus.req1 = 1'b1; bus.wr1 = 1'b1; bus.addr1 = 24'h000600; bus.wdata1 = 32'hDDDDDDDD;
    tick();
    n_vec++; if (ctl !== 6'b000000) begin n_err++; $display("FAIL resp_req_ignored: got %b want %b", ctl, 6'b000000); end
    tick();
    n_vec++; if (ctl !== 6'b101100) begin n_err++; $display("FAIL resp_req_taken: got %b want %b", ctl, 6'b101100); end
    n_vec++; if (bus.to_mem_data !== 32'hDDDDDDDD) begin n_err++; $display("FAIL resp_req_wdata: got %h want %h", bus.to_mem_data, 32'hDDDDDDDD); end
    bus.mem_rdy = 1'b1;
    tick();
    n_vec++; if (ctl !== 6'b000101) begin n_err++; $display("FAIL resp_req_ack1: got %b want %b", ctl, 6'b000101); end
    bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.mem_rdy = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g;
    logic       g;
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = 4'b0101;
`else
    exp_g = 4'b1111;
`endif
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 24'h000700;
    bus.req1 = 1'b1; bus.addr1 = 24'h000800;
    for (int k = 0; k < 4; k++) begin
      g = exp_g[k];
      tick();
      n_vec++; if (bus.mem_addr !== (g ? 24'h000800 : 24'h000700)) begin n_err++; $display("FAIL b2b_addr k%0d: got %h want %h", k, bus.mem_addr, (g ? 24'h000800 : 24'h000700)); end
      bus.mem_rdy = 1'b1; bus.from_mem_data = 32'h50000000 + 32'(k);
      tick();
      n_vec++; if (ctl !== (g ? 6'b000101 : 6'b000110)) begin n_err++; $display("FAIL b2b_ack k%0d: got %b want %b", k, ctl, (g ? 6'b000101 : 6'b000110)); end
      bus.mem_rdy = 1'b0;
      tick();
      n_vec++; if (ctl !== 6'b000000) begin n_err++; $display("FAIL b2b_idle k%0d: got %b want %b", k, ctl, 6'b000000); end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_read();
    test_write_wait();
    test_reset_mid_access();
    test_tie();
    test_hold_and_resp();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
